// File: rtl/ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_seq
// Brief    : Multi-cycle instruction control sequencer. Define CTRL_MEM_WAIT_EN
//            to stretch MEM until dm_ack; otherwise MEM lasts one cycle.
// Revision : 1.0  initial release
// ============================================================================
module ctrl_seq #(
   parameter int OPW  = 4,
   parameter int CCW  = 4,
   parameter int MMW  = 4,
   parameter int ALUW = 2,
   parameter int WBW  = 2
) (
   input  logic            clk,
   input  logic            rst_f,
   input  logic [OPW-1:0]  opcode,
   input  logic [MMW-1:0]  mm,
   input  logic [CCW-1:0]  stat,
   input  logic            dm_ack,
   input  logic            resume,
   output logic            rf_we,
   output logic            ir_load,
   output logic            pc_write,
   output logic            pc_sel,
   output logic            br_sel,
   output logic            pc_rst,
   output logic            rb_sel,
   output logic            dm_we,
   output logic            halted,
   output logic [ALUW-1:0] alu_op,
   output logic [WBW-1:0]  wb_sel,
   output logic [2:0]      state
);

   typedef enum logic [2:0] {
      ST_START0    = 3'd0,
      ST_START1    = 3'd1,
      ST_FETCH     = 3'd2,
      ST_DECODE    = 3'd3,
      ST_EXECUTE   = 3'd4,
      ST_MEM       = 3'd5,
      ST_WRITEBACK = 3'd6,
      ST_HALT      = 3'd7
   } state_t;

   localparam logic [OPW-1:0] c_op_lod = OPW'(1);
   localparam logic [OPW-1:0] c_op_str = OPW'(2);
   localparam logic [OPW-1:0] c_op_bra = OPW'(4);
   localparam logic [OPW-1:0] c_op_brr = OPW'(5);
   localparam logic [OPW-1:0] c_op_bne = OPW'(6);
   localparam logic [OPW-1:0] c_op_bnr = OPW'(7);
   localparam logic [OPW-1:0] c_op_alu = OPW'(8);
   localparam logic [OPW-1:0] c_op_hlt = {OPW{1'b1}};
   localparam logic [MMW-1:0] c_mm_imm = MMW'(8);

   state_t r_state;

   logic w_is_lod, w_is_str, w_is_bra, w_is_brr, w_is_bne, w_is_bnr;
   logic w_is_alu, w_is_hlt, w_cond, w_taken, w_mem_done;

   assign w_is_lod = (opcode == c_op_lod);
   assign w_is_str = (opcode == c_op_str);
   assign w_is_bra = (opcode == c_op_bra);
   assign w_is_brr = (opcode == c_op_brr);
   assign w_is_bne = (opcode == c_op_bne);
   assign w_is_bnr = (opcode == c_op_bnr);
   assign w_is_alu = (opcode == c_op_alu);
   assign w_is_hlt = (opcode == c_op_hlt);

   // Branch condition: any status flag selected by the low mask bits of mm.
   assign w_cond  = |(stat & mm[CCW-1:0]);
   assign w_taken = ((w_is_bra | w_is_brr) & w_cond) |
                    ((w_is_bne | w_is_bnr) & ~w_cond);

`ifdef CTRL_MEM_WAIT_EN
   assign w_mem_done = dm_ack;
`else
   logic w_unused_dm_ack;
   assign w_unused_dm_ack = dm_ack;
   assign w_mem_done      = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         r_state <= ST_START0;
      end else begin
         case (r_state)
            ST_START0:    r_state <= ST_START1;
            ST_START1:    r_state <= ST_FETCH;
            ST_FETCH:     r_state <= ST_DECODE;
            ST_DECODE: begin
               if (w_is_hlt)
                  r_state <= ST_HALT;
               else if (w_is_lod | w_is_str | w_is_alu)
                  r_state <= ST_EXECUTE;
               else
                  r_state <= ST_FETCH;
            end
            ST_EXECUTE:   r_state <= (w_is_lod | w_is_str) ? ST_MEM : ST_WRITEBACK;
            ST_MEM:       if (w_mem_done) r_state <= ST_WRITEBACK;
            ST_WRITEBACK: r_state <= ST_FETCH;
            ST_HALT:      if (resume) r_state <= ST_FETCH;
            default:      r_state <= ST_START0;
         endcase
      end
   end

   assign state = r_state;

   always_comb begin
      rf_we    = 1'b0;
      ir_load  = 1'b0;
      pc_write = 1'b0;
      pc_sel   = 1'b0;
      br_sel   = 1'b0;
      pc_rst   = 1'b0;
      rb_sel   = 1'b0;
      dm_we    = 1'b0;
      halted   = 1'b0;
      alu_op   = '0;
      wb_sel   = '0;
      case (r_state)
         ST_START0, ST_START1: pc_rst = 1'b1;
         ST_FETCH: begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
         end
         ST_DECODE: begin
            pc_write = w_taken;
            pc_sel   = w_taken;
            br_sel   = w_is_bra | w_is_bne;
            rb_sel   = w_is_str;
         end
         ST_EXECUTE: begin
            if (w_is_alu)
               alu_op = (mm == c_mm_imm) ? ALUW'(1) : ALUW'(0);
            else if (w_is_lod | w_is_str)
               alu_op = ALUW'(2);
            rb_sel = w_is_str;
         end
         ST_MEM: begin
            alu_op = ALUW'(2);
            dm_we  = w_is_str;
            rb_sel = w_is_str;
         end
         ST_WRITEBACK: begin
            rf_we  = w_is_alu | w_is_lod;
            wb_sel = w_is_lod ? WBW'(1) : WBW'(0);
         end
         ST_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_seq.sv
`default_nettype none
// Self-checking bench for ctrl_seq: directed vectors, hand sequences for
// reset/HALT/MEM corners, and randomized instruction streams.
`timescale 1ns/1ps
module tb_ctrl_seq;

`ifdef CTRL_MEM_WAIT_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_f = 1'b0;
   logic [3:0] opcode = '0, mm = '0, stat = '0;
   logic       dm_ack = 1'b0, resume = 1'b0;
   logic       rf_we, ir_load, pc_write, pc_sel, br_sel, pc_rst, rb_sel, dm_we, halted;
   logic [1:0] alu_op, wb_sel;
   logic [2:0] state;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ctrl_seq #(.OPW(4), .CCW(4), .MMW(4), .ALUW(2), .WBW(2)) dut (
      .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
      .dm_ack(dm_ack), .resume(resume),
      .rf_we(rf_we), .ir_load(ir_load), .pc_write(pc_write), .pc_sel(pc_sel),
      .br_sel(br_sel), .pc_rst(pc_rst), .rb_sel(rb_sel), .dm_we(dm_we),
      .halted(halted), .alu_op(alu_op), .wb_sel(wb_sel), .state(state)
   );

   // {rf_we, ir_load, pc_write, pc_sel, br_sel, pc_rst, rb_sel, dm_we, halted, alu_op, wb_sel, state}
   wire [15:0] act = {rf_we, ir_load, pc_write, pc_sel, br_sel, pc_rst, rb_sel,
                      dm_we, halted, alu_op, wb_sel, state};

   // Expected outputs for a given phase of an instruction.
   function automatic logic [15:0] exp_vec(input int ph, input logic [3:0] op,
                                           input logic [3:0] m, input logic [3:0] s);
      bit rf = 0, irl = 0, pw = 0, ps = 0, bs = 0, prst = 0, rb = 0, we = 0, hl = 0;
      logic [1:0] alu = 0, wb = 0;
      bit lod = (op == 1), str = (op == 2), alu_i = (op == 8);
      bit pos_br = (op == 4) || (op == 5), neg_br = (op == 6) || (op == 7);
      bit cond = ((s & m) != 0);
      case (ph)
         0, 1: prst = 1;
         2: begin irl = 1; pw = 1; end
         3: begin
            pw = (pos_br && cond) || (neg_br && !cond);
            ps = pw;
            bs = (op == 4) || (op == 6);
            rb = str;
         end
         4: begin
            if (alu_i) alu = (m == 8) ? 2'd1 : 2'd0;
            else if (lod || str) alu = 2'd2;
            rb = str;
         end
         5: begin alu = 2'd2; we = str; rb = str; end
         6: begin rf = alu_i || lod; wb = lod ? 2'd1 : 2'd0; end
         7: hl = 1;
         default: ;
      endcase
      return {rf, irl, pw, ps, bs, prst, rb, we, hl, alu, wb, 3'(ph)};
   endfunction

   typedef int iq_t[$];

   // Sequence of states an instruction walks through, starting at FETCH.
   function automatic iq_t phases(input logic [3:0] op);
      iq_t q;
      q.push_back(2);
      q.push_back(3);
      if (op == 1 || op == 2) begin q.push_back(4); q.push_back(5); q.push_back(6); end
      else if (op == 8) begin q.push_back(4); q.push_back(6); end
      else if (op == 15) q.push_back(7);
      return q;
   endfunction

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [3:0] op, m, s;
      logic [3:0] dec;   // {pc_write, pc_sel, br_sel, rb_sel} in DECODE
      logic [1:0] ex_alu;
      int         ncyc;
   } vec_t;

   vec_t tbl[12];

   initial begin
      logic [3:0] dec_got;
      logic [1:0] alu_got;
      int         n;
      iq_t        ph;

      tbl[0]  = '{4'd4, 4'b0010, 4'b0010, 4'b1110, 2'd0, 2};
      tbl[1]  = '{4'd4, 4'b0010, 4'b0001, 4'b0010, 2'd0, 2};
      tbl[2]  = '{4'd7, 4'b0100, 4'b0000, 4'b1100, 2'd0, 2};
      tbl[3]  = '{4'd8, 4'd8,    4'b0000, 4'b0000, 2'd1, 4};
      tbl[4]  = '{4'd8, 4'd3,    4'b1111, 4'b0000, 2'd0, 4};
      tbl[5]  = '{4'd1, 4'd0,    4'b0000, 4'b0000, 2'd2, 5};
      tbl[6]  = '{4'd2, 4'd0,    4'b0000, 4'b0001, 2'd2, 5};
      tbl[7]  = '{4'd6, 4'b0001, 4'b0001, 4'b0010, 2'd0, 2};
      tbl[8]  = '{4'd5, 4'b1000, 4'b1000, 4'b1100, 2'd0, 2};
      tbl[9]  = '{4'd0, 4'b1111, 4'b1111, 4'b0000, 2'd0, 2};
      tbl[10] = '{4'd3, 4'b1111, 4'b0000, 4'b0000, 2'd0, 2};
      tbl[11] = '{4'd12, 4'd8,   4'b0000, 4'b0000, 2'd0, 2};

      // Power-up reset held three cycles, then release.
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("reset_hold", act, exp_vec(0, opcode, mm, stat));
         tick();
      end
      rst_f = 1'b1;
      #1;
      chk("reset_release", act, exp_vec(0, opcode, mm, stat));
      tick();
      chk("start1", act, exp_vec(1, opcode, mm, stat));
      tick();
      chk("first_fetch", act, exp_vec(2, opcode, mm, stat));

      // Directed vectors: DECODE strobes, EXECUTE alu_op and instruction length.
      for (int t = 0; t < 12; t++) begin
         opcode = tbl[t].op; mm = tbl[t].m; stat = tbl[t].s;
         dm_ack = 1'b1; resume = 1'b0;
         dec_got = '0; alu_got = '0; n = 0;
         do begin
            #1;
            if (state == 3'd3) dec_got = {pc_write, pc_sel, br_sel, rb_sel};
            if (state == 3'd4) alu_got = alu_op;
            n++;
            tick();
         end while (state != 3'd2 && n < 20);
         chk($sformatf("vec%0d_decode", t), 16'(dec_got), 16'(tbl[t].dec));
         chk($sformatf("vec%0d_exec_alu", t), 16'(alu_got), 16'(tbl[t].ex_alu));
         chk($sformatf("vec%0d_cycles", t), 16'(n), 16'(tbl[t].ncyc));
      end

      // HALT: holds with resume low, leaves one cycle after resume.
      opcode = 4'd15; mm = '0; stat = '0; resume = 1'b0;
      tick(); tick();
      for (int i = 0; i < 10; i++) begin
         chk("halt_hold", act, exp_vec(7, opcode, mm, stat));
         tick();
      end
      resume = 1'b1;
      #1;
      tick();
      resume = 1'b0;
      chk("halt_resume", act, exp_vec(2, opcode, mm, stat));

      // STR through MEM with dm_ack low for three cycles.
      opcode = 4'd2; dm_ack = 1'b0;
      tick(); tick(); tick();
      if (WAIT_EN) begin
         for (int i = 0; i < 4; i++) begin
            if (i == 3) dm_ack = 1'b1;
            #1;
            chk("mem_wait", act, exp_vec(5, opcode, mm, stat));
            tick();
         end
      end else begin
         chk("mem_single", act, exp_vec(5, opcode, mm, stat));
         tick();
      end
      chk("str_writeback", act, exp_vec(6, opcode, mm, stat));
      tick();
      chk("str_back_fetch", act, exp_vec(2, opcode, mm, stat));

      // Asynchronous reset in the middle of a LOD MEM cycle.
      opcode = 4'd1; dm_ack = 1'b0;
      tick(); tick(); tick();
      #1;
      chk("lod_in_mem", act, exp_vec(5, opcode, mm, stat));
      rst_f = 1'b0;
      #1;
      chk("async_reset_mid_mem", act, exp_vec(0, opcode, mm, stat));
      tick(); tick();
      rst_f = 1'b1;
      dm_ack = 1'b1;
      tick();
      chk("restart_start1", act, exp_vec(1, opcode, mm, stat));
      tick();
      chk("restart_fetch", act, exp_vec(2, opcode, mm, stat));

      // Randomized instruction stream against the phase model.
      for (int k = 0; k < 300; k++) begin
         logic [3:0] op, m, s;
         op = 4'($urandom_range(0, 15));
         m  = 4'($urandom);
         s  = 4'($urandom);
         if ($urandom_range(0, 3) == 0) m = 4'd8;
         opcode = op; mm = m; stat = s;
         ph = phases(op);
         foreach (ph[j]) begin
            if (ph[j] == 7) begin
               int hold = $urandom_range(0, 4);
               for (int h = 0; h <= hold; h++) begin
                  resume = (h == hold);
                  #1;
                  chk("rand_halt", act, exp_vec(7, op, m, s));
                  tick();
               end
            end else if (ph[j] == 5) begin
               int  w = 0;
               bit  stay;
               do begin
                  dm_ack = (w >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
                  resume = 1'($urandom_range(0, 1));
                  #1;
                  chk("rand_mem", act, exp_vec(5, op, m, s));
                  stay = WAIT_EN && !dm_ack;
                  w++;
                  tick();
               end while (stay);
            end else begin
               dm_ack = 1'($urandom_range(0, 1));
               resume = 1'($urandom_range(0, 1));
               #1;
               chk("rand_step", act, exp_vec(ph[j], op, m, s));
               tick();
            end
         end
         resume = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 Parameter OPW, default 4, opcode field width.
REQ-002 Parameter CCW, default 4, width of status flags and of the branch condition mask.
REQ-003 Parameter MMW, default 4, mode-field width; MMW SHALL be >= CCW.
REQ-004 Parameter ALUW, default 2, ALU operation select width.
REQ-005 Parameter WBW, default 2, writeback mux select width.
REQ-006 clk  in  1  single clock; all state changes on posedge.
REQ-007 rst_f  in  1  reset, asynchronous, active-low.
REQ-008 opcode  in  OPW  current instruction opcode, stable from DECODE through WRITEBACK.
REQ-009 mm  in  MMW  mode/condition mask field; low CCW bits form the branch mask.
REQ-010 stat  in  CCW  status flags.
REQ-011 dm_ack  in  1  data-memory completion.
REQ-012 resume  in  1  leave HALT.
REQ-013 rf_we, ir_load, pc_write, pc_sel, br_sel, pc_rst, rb_sel, dm_we, halted  out  1 each  control strobes.
REQ-014 alu_op  out  ALUW; wb_sel  out  WBW; state  out  3  current state code.

Function
REQ-015 States and codes: START0=0, START1=1, FETCH=2, DECODE=3, EXECUTE=4, MEM=5, WRITEBACK=6, HALT=7; state register only, outputs decoded combinationally from state, opcode, mm and stat.
REQ-016 Opcodes: NOOP=0, LOD=1, STR=2, BRA=4, BRR=5, BNE=6, BNR=7, ALU=8, HLT=all-ones in OPW bits; any other value is treated as NOOP.
REQ-017 Transitions: START0->START1->FETCH->DECODE; DECODE->FETCH for NOOP/branches, ->HALT for HLT, else ->EXECUTE; EXECUTE->MEM for LOD/STR, else ->WRITEBACK; MEM->WRITEBACK; WRITEBACK->FETCH; HALT->FETCH when resume=1, else stays in HALT.
REQ-018 All outputs 0 in every state unless asserted below; alu_op and wb_sel default 0.
REQ-019 START0, START1: pc_rst=1.
REQ-020 FETCH: ir_load=1, pc_write=1.
REQ-021 DECODE: cond = |(stat & mm[CCW-1:0]); taken = cond for BRA/BRR and !cond for BNE/BNR; when taken, pc_write=1 and pc_sel=1; br_sel=1 for BRA/BNE, 0 for BRR/BNR; rb_sel=1 for STR.
REQ-022 EXECUTE: alu_op=1 for ALU with mm==8 (immediate), alu_op=0 for ALU otherwise, alu_op=2 for LOD/STR; rb_sel=1 for STR.
REQ-023 MEM: alu_op=2; dm_we=1 for STR; rb_sel=1 for STR.
REQ-024 WRITEBACK: rf_we=1 for ALU and LOD; wb_sel=1 for LOD, 0 for ALU.
REQ-025 HALT: halted=1, all other strobes 0; HALT is entered only from DECODE with opcode HLT, never from any other state.
REQ-026 Latency: branch/NOOP 2 cycles, ALU 4 cycles, LOD/STR 5 cycles (no wait states).
REQ-027 A resume pulse outside HALT SHALL be ignored.

Reset
REQ-028 rst_f=0 SHALL force state=START0 immediately, independent of clk, including mid-instruction and during MEM wait.
REQ-029 During reset: pc_rst=1, every other output 0, state=0.
REQ-030 After rst_f rises, the first posedge moves to START1; FETCH is reached on the second posedge.

Configuration
REQ-031 Macro CTRL_MEM_WAIT_EN defined: MEM holds while dm_ack=0, with dm_we (STR) and alu_op held steady; MEM->WRITEBACK on the posedge where dm_ack=1; dm_ack=1 on the first MEM cycle gives zero wait.
REQ-032 Macro CTRL_MEM_WAIT_EN undefined: dm_ack is ignored and MEM lasts exactly one cycle.

Verification
REQ-033 rst_f low for 3 cycles, then high -> state 0,0,0 with pc_rst=1, then state 1, then state 2 with ir_load=1 and pc_write=1.
REQ-034 opcode=4, mm=4'b0010, stat=4'b0010 -> DECODE asserts pc_write=1, pc_sel=1, br_sel=1; next state FETCH; stat=4'b0001 -> pc_write=0.
REQ-035 opcode=7, mm=4'b0100, stat=0 -> taken, br_sel=0, pc_sel=1; opcode=8, mm=8 -> EXECUTE alu_op=1, WRITEBACK rf_we=1, wb_sel=0, 4 cycles total.
REQ-036 CTRL_MEM_WAIT_EN, opcode=2, dm_ack low 3 cycles -> MEM held 4 cycles with dm_we=1 throughout; WRITEBACK follows with rf_we=0.
REQ-037 opcode=15 -> HALT with halted=1 for 10 cycles at resume=0; resume=1 -> FETCH next cycle.
REQ-038 rst_f dropped mid-MEM of LOD -> state=0 and dm_we=0 before the next posedge; normal restart follows.
